// File: rtl/fifo_rd_ptr_sync_if.sv
// Read-side pointer sync bundle: async FIFO consumer-domain status and RAM read port.
// Latency: wire bundle only; no storage.
// Backpressure: none here; rd_en is only honoured by the block when the FIFO is non-empty.
//
// Ports (master = consumer/producer-pointer driver, slave = fifo_rd_ptr_sync):
//   w_ptr_gray    producer Gray write pointer (asynchronous to the consumer clock)
//   rd_en/clr_err consumer read request and sticky-error clear
//   pop/r_add     RAM read enable and address
//   r_ptr_gray    registered Gray read pointer toward the producer domain
//   empty/almost_empty/level/underflow_err/ptr_err  status
interface fifo_rd_ptr_sync_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH:0]   w_ptr_gray;
  logic                  rd_en;
  logic                  clr_err;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] r_add;
  logic [ADDR_WIDTH:0]   r_ptr_gray;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  underflow_err;
  logic                  ptr_err;

  modport master (
    output w_ptr_gray, rd_en, clr_err,
    input  pop, r_add, r_ptr_gray, empty, almost_empty, level, underflow_err, ptr_err
  );

  modport slave (
    input  w_ptr_gray, rd_en, clr_err,
    output pop, r_add, r_ptr_gray, empty, almost_empty, level, underflow_err, ptr_err
  );
endinterface

// File: rtl/fifo_rd_ptr_sync.sv
// Async FIFO read-side: syncs the producer Gray write pointer, owns the read pointer, makes status.
// Latency: write pointer visible in level SYNC_STAGES+1 edges after it settles; pop advances on the same edge.
// Backpressure: pops are suppressed while empty (flagged as underflow); no other stalls.
//
// Ports:
//   clk    consumer-domain clock
//   reset  asynchronous active-low reset
//   bus    fifo_rd_ptr_sync_if slave modport (pointer in, RAM read port, status out)
module fifo_rd_ptr_sync #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,  // 2..4
  parameter int AE_THRESH   = 2   // 0..DEPTH-1
) (
  input  logic             clk,
  input  logic             reset,
  fifo_rd_ptr_sync_if.slave bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  ptr_t sync_q [SYNC_STAGES];
  ptr_t wbin_q;
  ptr_t rbin_q;
  ptr_t rgray_q;
  logic underflow_q;
  logic ptr_err_q;

  ptr_t rbin_next;
  ptr_t level_c;
  logic empty_c;
  logic pop_c;
  logic underflow_set;
  logic ptr_err_set;

  // Plain flop chain: nothing may sit between stages, or metastability
  // settling time is eaten by logic delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.w_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Gray-to-binary is registered so status logic only ever sees a clean
  // binary pointer, never the raw synchroniser output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbin_q <= '0;
    end else begin
      wbin_q <= gray2bin(sync_q[SYNC_STAGES-1]);
    end
  end

  // Modulo subtraction across the extra wrap bit gives 0..DEPTH for a sane
  // pointer pair; anything larger means the pointers have been corrupted.
  always_comb begin
    level_c       = wbin_q - rbin_q;
    empty_c       = (level_c == '0);
    pop_c         = bus.rd_en && !empty_c;
    rbin_next     = rbin_q + ptr_t'(pop_c);
    underflow_set = bus.rd_en && empty_c;
    ptr_err_set   = (level_c > ptr_t'(DEPTH));
  end

  // Gray copy is computed from rbin_next so it is a registered, single-bit
  // change per pop, safe to cross into the producer domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rbin_q  <= '0;
      rgray_q <= '0;
    end else begin
      rbin_q  <= rbin_next;
      rgray_q <= bin2gray(rbin_next);
    end
  end

  // Sticky flags: a coinciding set condition beats clr_err so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow_q <= 1'b0;
      ptr_err_q   <= 1'b0;
    end else begin
      if (underflow_set) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
      if (ptr_err_set) begin
        ptr_err_q <= 1'b1;
      end else if (bus.clr_err) begin
        ptr_err_q <= 1'b0;
      end
    end
  end

  assign bus.pop           = pop_c;
  assign bus.r_add         = rbin_q[ADDR_WIDTH-1:0];
  assign bus.r_ptr_gray    = rgray_q;
  assign bus.empty         = empty_c;
  assign bus.almost_empty  = (level_c <= ptr_t'(AE_THRESH));
  assign bus.level         = level_c;
  assign bus.underflow_err = underflow_q;
  assign bus.ptr_err       = ptr_err_q;

endmodule

// File: tb/tb_fifo_rd_ptr_sync.sv
module tb_fifo_rd_ptr_sync;

  localparam int AW = 4;
  typedef logic [AW:0] ptr_t;

  typedef struct packed {
    logic          pop;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fifo_rd_ptr_sync_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_rd_ptr_sync #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(2),
    .AE_THRESH  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   w_cnt  = 0;  // unwrapped count of entries the producer has published
  int   r_cnt  = 0;  // unwrapped count of entries consumed
  logic uf_m   = 1'b0;

  function automatic ptr_t to_gray(input int c);
    ptr_t b;
    b = ptr_t'(c);
    return b ^ (b >> 1);
  endfunction

  function automatic int model_level();
    ptr_t d;
    d = ptr_t'(w_cnt - r_cnt);
    return int'(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pop"},   32'(bus.pop), 32'(0));
    chk({tag, "_radd"},  32'(bus.r_add), 32'(0));
    chk({tag, "_rgray"}, 32'(bus.r_ptr_gray), 32'(0));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(1));
    chk({tag, "_ae"},    32'(bus.almost_empty), 32'(1));
    chk({tag, "_level"}, 32'(bus.level), 32'(0));
    chk({tag, "_uflow"}, 32'(bus.underflow_err), 32'(0));
    chk({tag, "_perr"},  32'(bus.ptr_err), 32'(0));
  endtask

  task automatic check_status(input string tag);
    ptr_t rb;
    int   l;
    rb = ptr_t'(r_cnt);
    l  = model_level();
    chk({tag, "_level"}, 32'(bus.level), 32'(l));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(l == 0));
    chk({tag, "_ae"},    32'(bus.almost_empty), 32'(l <= 2));
    chk({tag, "_rgray"}, 32'(bus.r_ptr_gray), 32'(to_gray(r_cnt)));
    chk({tag, "_radd"},  32'(bus.r_add), 32'(rb[AW-1:0]));
  endtask

  task automatic step_w();
    @(negedge clk);
    w_cnt++;
    bus.w_ptr_gray = to_gray(w_cnt);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One read cycle: expectation queued at drive time, popped when the DUT's
  // combinational read port is sampled, then registered state checked.
  task automatic read1(input string tag);
    exp_t e;
    ptr_t rb;
    @(negedge clk);
    bus.rd_en = 1'b1;
    rb     = ptr_t'(r_cnt);
    e.pop  = (model_level() != 0);
    e.addr = rb[AW-1:0];
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_pop"},  32'(bus.pop), 32'(e.pop));
    chk({tag, "_addr"}, 32'(bus.r_add), 32'(e.addr));
    if (e.pop) r_cnt++;
    else uf_m = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    check_status(tag);
    chk({tag, "_uflow"}, 32'(bus.underflow_err), 32'(uf_m));
  endtask

  initial begin
    int n;
    bus.w_ptr_gray = '0;
    bus.rd_en      = 1'b0;
    bus.clr_err    = 1'b0;

    #12;
    check_reset("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset("rst_rel");

    // Fill latency: pointer published before edge 0, visible after edge 2.
    @(negedge clk);
    w_cnt = 3;
    bus.w_ptr_gray = to_gray(w_cnt);
    @(posedge clk); #1;
    chk("fill_e0_empty", 32'(bus.empty), 32'(1));
    @(posedge clk); #1;
    chk("fill_e1_empty", 32'(bus.empty), 32'(1));
    @(posedge clk); #1;
    check_status("fill_e2");

    // Drain back-to-back.
    repeat (3) read1("drain");

    // Underflow, hold, set-wins-over-clear, then clear.
    read1("uflow");
    @(posedge clk); #1;
    chk("uflow_hold", 32'(bus.underflow_err), 32'(1));
    @(negedge clk);
    bus.rd_en   = 1'b1;
    bus.clr_err = 1'b1;
    #1;
    chk("uflow_setwin_pop", 32'(bus.pop), 32'(0));
    @(posedge clk); #1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    chk("uflow_setwin", 32'(bus.underflow_err), 32'(1));
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
    uf_m = 1'b0;
    chk("uflow_clr", 32'(bus.underflow_err), 32'(0));

    // Wrap: advance in small batches up to rbin=30 with wbin=34.
    while (r_cnt < 30) begin
      while (w_cnt < r_cnt + 4 && w_cnt < 34) step_w();
      settle();
      check_status("wrap_fill");
      n = (30 - r_cnt < 4) ? 30 - r_cnt : 4;
      repeat (n) read1("wrap_rd");
    end
    while (w_cnt < 34) step_w();
    settle();
    check_status("wrap_34");
    repeat (4) read1("wrap_pop");

    // Set underflow, reload some entries, then reset mid-stream.
    read1("uflow2");
    repeat (3) step_w();
    settle();
    check_status("pre_rst");
    @(negedge clk);
    bus.rd_en = 1'b1;
    #2;
    reset = 1'b0;
    bus.w_ptr_gray = '0;
    #1;
    check_reset("async_rst");
    bus.rd_en = 1'b0;
    w_cnt = 0;
    r_cnt = 0;
    uf_m  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset("rst_hold");

    // Corruption: write pointer 17 ahead of a zero read pointer.
    @(negedge clk);
    w_cnt = 17;
    bus.w_ptr_gray = 5'b11001;
    settle();
    chk("perr_level", 32'(bus.level), 32'(17));
    chk("perr_pre", 32'(bus.ptr_err), 32'(0));
    @(posedge clk); #1;
    chk("perr_set", 32'(bus.ptr_err), 32'(1));
    read1("perr_pop");
    chk("perr_sticky", 32'(bus.ptr_err), 32'(1));
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
    chk("perr_clr", 32'(bus.ptr_err), 32'(0));

    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ptr_sync.md
# fifo_rd_ptr_sync

Read-side pointer synchroniser and status generator for the parametrised asynchronous FIFO, clocked in the consumer (processor) domain. It brings the producer's Gray-coded write pointer across the boundary with a configurable flop chain and converts it to binary. It owns the binary read pointer and exports its registered Gray copy to the producer domain. It produces empty, almost-empty, fill level, underflow and pointer-corruption status, generalising the fixed two-flop empty comparator with depth, sync-depth and threshold parameters.

## Interface
- ADDR_WIDTH, 4: RAM address bits; FIFO depth DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
- SYNC_STAGES, 2: number of synchroniser flops on w_ptr_gray; legal range 2..4.
- AE_THRESH, 2: almost_empty asserts when level <= AE_THRESH; legal range 0..DEPTH-1.
- clk  in  1  consumer-domain clock; single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- w_ptr_gray  in  ADDR_WIDTH+1  producer write pointer, Gray-coded, asynchronous to clk.
- rd_en  in  1  consumer read request.
- clr_err  in  1  synchronous clear of the sticky error flags.
- pop  out  1  combinational rd_en && !empty; RAM read enable.
- r_add  out  ADDR_WIDTH  RAM read address, equal to rbin[ADDR_WIDTH-1:0].
- r_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the producer domain.
- empty  out  1  FIFO holds no readable entry.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  ADDR_WIDTH+1  entries available, 0..DEPTH.
- underflow_err  out  1  sticky; set when a read is requested while empty.
- ptr_err  out  1  sticky; set when the computed level exceeds DEPTH.

## Operation
- Sync chain: SYNC_STAGES flops, sync[0] <= w_ptr_gray, sync[i] <= sync[i-1]. No logic sits between stages.
- wbin_q register: wbin_q <= gray2bin(sync[SYNC_STAGES-1]). This is the only consumer of the chain.
- rbin register (ADDR_WIDTH+1 bits): rbin <= rbin + 1 modulo 2^(ADDR_WIDTH+1) when pop is high; otherwise it holds.
- r_ptr_gray register: r_ptr_gray <= bin2gray(rbin_next). It always equals bin2gray(rbin), changes one bit per pop and is glitch-free.
- level = (wbin_q - rbin) modulo 2^(ADDR_WIDTH+1), unsigned, with wrap-around handled by the modulo.
- empty = (level == 0). almost_empty = (level <= AE_THRESH). All three are combinational from registers only.
- Underflow: rd_en && empty means no pop and no pointer change; underflow_err sets on the next edge.
- Corruption: level > DEPTH sets ptr_err on the next edge. No pop is blocked by ptr_err.
- Sticky flags: clr_err clears both flags on the next edge. If a set condition and clr_err coincide, set wins.
- Reset (asynchronous, any time, including mid-transfer): all sync flops, wbin_q, rbin, r_ptr_gray and both error flags go to 0.
- Reset output values: pop=0, r_add=0, r_ptr_gray=0, empty=1, almost_empty=1, level=0, underflow_err=0, ptr_err=0.

## Timing
- A w_ptr_gray change that is stable before edge N is visible in level/empty after edge N+SYNC_STAGES (SYNC_STAGES+1 edges). With the default of 2, that is edge N+2.
- Pop latency: rd_en high with empty low at edge N advances rbin, r_add, r_ptr_gray and level at edge N.
- Back-to-back pops: one pop per cycle while level > 0. empty asserts in the same cycle the last entry is consumed, i.e. level reaches 0 after that edge.
- Pessimism: empty may stay high for up to SYNC_STAGES+1 cycles after a write. It never falsely deasserts.
- Error flags: set 1 edge after the condition occurs.

## Test plan
- Reset: hold reset=0 mid-stream -> all outputs at reset values immediately (asynchronously); they remain there for 1 cycle after release.
- Fill latency (defaults): w_ptr_gray=5'b00010 (bin 3) stable before edge 0 -> empty=1 through edge 1; after edge 2: empty=0, level=3, almost_empty=0.
- Drain: rd_en=1 for 3 cycles -> r_add 0,1,2; r_ptr_gray 00001, 00011, 00010; level 2 (almost_empty=1), then 1, then 0 (empty=1).
- Underflow: rd_en=1 while empty -> pop=0, rbin unchanged, underflow_err=1 and held; clr_err=1 for one cycle -> 0.
- Wrap: step w_ptr one count at a time to bin 34 mod 32 = 2 while reading up to rbin=30 -> level=4. Continue popping past 31 -> r_ptr_gray goes 10000 -> 00000 and r_add goes 15 -> 0.
- Corruption: rbin=0, w_ptr_gray=5'b11001 (bin 17) -> level=17 and ptr_err=1 after the sync latency.
